// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
//   Shared types and constants for the SRAM access sequencer.
//   seq_state_t : sequencer FSM states (IDLE, SETUP, ACCESS, DONE)
//   port_t      : requester identity (CPU, DBG)
//   WS_CNT_W    : width of the wait-state counter (covers WAIT_STATES 1..15)
// ---------------------------------------------------------------------------
package mem_seq_pkg;

  localparam int WS_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } seq_state_t;

  typedef enum logic {
    CPU,
    DBG
  } port_t;

endpackage

// File: rtl/mem_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
//   Loadable down-counter that times the ACCESS phase. It stops at zero.
//   Ports:
//     Clk, Reset_n : clock, asynchronous active-low reset
//     load         : load load_val (has priority over dec)
//     load_val     : value to load
//     dec          : decrement by one when non-zero
//     zero         : count is zero
// ---------------------------------------------------------------------------
module mem_wait_counter
  import mem_seq_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                load,
  input  logic [WS_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [WS_CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//   Multi-cycle SRAM access sequencer with a two-port (CPU / debug) arbiter.
//   A requester raises *_req and holds it until a one-cycle *_ack; the block
//   generates the SRAM strobes with a fixed number of wait states.
//   Transfer: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE -> IDLE,
//   so ack arrives WAIT_STATES+2 cycles after the request is sampled.
//
//   Parameters: AW address width, DW data width, WAIT_STATES (1..15).
//   Configuration macro: MEM_SEQ_RR_ARB_EN
//     defined   -> round-robin arbitration using last_grant
//     undefined -> fixed priority, CPU over DBG
//
//   Ports:
//     Clk, Reset_n                          clock, async active-low reset
//     cpu_req/we/addr/wdata, cpu_ack/rdata  CPU port
//     dbg_req/we/addr/wdata, dbg_ack/rdata  debug/loader port
//     sram_addr, sram_wdata, sram_rdata     SRAM address/data
//     sram_drive                            tristate enable for sram_wdata
//     sram_ce_n, sram_oe_n, sram_we_n       active-low SRAM strobes
//     busy                                  high whenever not IDLE
// ---------------------------------------------------------------------------
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AW          = 20,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          sram_drive,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          busy
);

  localparam logic [WS_CNT_W-1:0] WS_LOAD = WS_CNT_W'(WAIT_STATES - 1);

  seq_state_t state;
  port_t      cur_port;   // grantee of the transfer in flight
  logic       cur_we;     // latched direction of the transfer in flight

  port_t      grant;
  logic       any_req;
  logic       cnt_zero;

  assign any_req = cpu_req | dbg_req;

  // -------------------------------------------------------------------------
  // Arbiter. grant is only consumed in IDLE when any_req is high.
  // -------------------------------------------------------------------------
`ifdef MEM_SEQ_RR_ARB_EN
  port_t last_grant;

  // On a tie the port that did not win last time goes first; a lone
  // requester always wins.
  assign grant = (cpu_req && (!dbg_req || (last_grant == DBG))) ? CPU : DBG;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_grant <= DBG;
    end else if ((state == IDLE) && any_req) begin
      last_grant <= grant;
    end
  end
`else
  assign grant = cpu_req ? CPU : DBG;
`endif

  // -------------------------------------------------------------------------
  // ACCESS-phase timer: loaded in SETUP, counts down through ACCESS.
  // -------------------------------------------------------------------------
  mem_wait_counter u_wait_counter (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (state == SETUP),
    .load_val (WS_LOAD),
    .dec      (state == ACCESS),
    .zero     (cnt_zero)
  );

  // -------------------------------------------------------------------------
  // Sequencer FSM. All outputs are registered and set on the edge that
  // enters the state they belong to.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cur_port   <= CPU;
      cur_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the ACCESS->DONE edge raises one.
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            // Latch the grantee's request; it stays frozen until DONE.
            cur_port   <= grant;
            cur_we     <= (grant == CPU) ? cpu_we    : dbg_we;
            sram_addr  <= (grant == CPU) ? cpu_addr  : dbg_addr;
            sram_wdata <= (grant == CPU) ? cpu_wdata : dbg_wdata;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= (grant == CPU) ? cpu_we    : dbg_we;
            sram_drive <= (grant == CPU) ? cpu_we    : dbg_we;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end

        SETUP: begin
          // Address has had one cycle of setup; now assert we_n for writes.
          sram_we_n <= ~cur_we;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (cnt_zero) begin
            if (!cur_we) begin
              if (cur_port == CPU) cpu_rdata <= sram_rdata;
              else                 dbg_rdata <= sram_rdata;
            end
            cpu_ack   <= (cur_port == CPU);
            dbg_ack   <= (cur_port == DBG);
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Write data was held through DONE; release the bus now.
          sram_drive <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_access_sequencer
//   Directed bench for mem_access_sequencer. Cycle numbering: cycle 0 is the
//   IDLE cycle in which a request is first sampled; cycle n is observed 1 time
//   unit after the n-th rising edge that follows. Per-cycle behaviour is
//   recorded into 16-bit traces (bit n = cycle n) and compared to
//   hand-computed masks. A second instance with WAIT_STATES=1 covers the
//   minimum-latency case.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;

  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, sram_rdata;
  logic          cpu_ack, dbg_ack;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_drive, sram_ce_n, sram_oe_n, sram_we_n, busy;

  // WAIT_STATES=1 instance
  logic          w1_req;
  logic          w1_cpu_ack, w1_dbg_ack;
  logic [DW-1:0] w1_cpu_rdata, w1_dbg_rdata, w1_sram_wdata;
  logic [AW-1:0] w1_sram_addr;
  logic          w1_drive, w1_ce_n, w1_oe_n, w1_we_n, w1_busy;
  logic          zero_bit = 1'b0;
  logic [AW-1:0] zero_addr = '0;
  logic [DW-1:0] zero_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] tr_cpu, tr_dbg, tr_oe, tr_we, tr_drv, tr_busy, tr_wd, tr_dchg;
  logic [DW-1:0] dbg_ref;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(.AW(AW), .DW(DW), .WAIT_STATES(2)) u_dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_drive (sram_drive),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .busy       (busy)
  );

  mem_access_sequencer #(.AW(AW), .DW(DW), .WAIT_STATES(1)) u_dut_ws1 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .cpu_req    (w1_req),
    .cpu_we     (zero_bit),
    .cpu_addr   (zero_addr),
    .cpu_wdata  (zero_data),
    .cpu_ack    (w1_cpu_ack),
    .cpu_rdata  (w1_cpu_rdata),
    .dbg_req    (zero_bit),
    .dbg_we     (zero_bit),
    .dbg_addr   (zero_addr),
    .dbg_wdata  (zero_data),
    .dbg_ack    (w1_dbg_ack),
    .dbg_rdata  (w1_dbg_rdata),
    .sram_addr  (w1_sram_addr),
    .sram_wdata (w1_sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_drive (w1_drive),
    .sram_ce_n  (w1_ce_n),
    .sram_oe_n  (w1_oe_n),
    .sram_we_n  (w1_we_n),
    .busy       (w1_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Record n cycles starting with the current one. cpu_req is dropped after
  // cpu_hold acks; dbg_req is dropped on its first ack.
  task automatic capture(input int n, input int cpu_hold);
    int cpu_acks = 0;
    tr_cpu = '0; tr_dbg = '0; tr_oe = '0; tr_we = '0;
    tr_drv = '0; tr_busy = '0; tr_wd = '0; tr_dchg = '0;
    for (int c = 0; c < n; c++) begin
      tr_cpu[c]  = cpu_ack;
      tr_dbg[c]  = dbg_ack;
      tr_oe[c]   = ~sram_oe_n;
      tr_we[c]   = ~sram_we_n;
      tr_drv[c]  = sram_drive;
      tr_busy[c] = busy;
      tr_wd[c]   = (sram_wdata == 16'hBEEF);
      tr_dchg[c] = (dbg_rdata != dbg_ref);
      if (cpu_ack) begin
        cpu_acks++;
        if (cpu_acks >= cpu_hold) cpu_req = 1'b0;
      end
      if (dbg_ack) dbg_req = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [15:0] w1_ack_tr, w1_oe_tr;
    bit seen;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    sram_rdata = '0; w1_req = 0; dbg_ref = '0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #2;

    // ---- reset state ----
    check("rst_busy",  busy, 0);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 4'b1110);
    check("rst_acks",  {cpu_ack, dbg_ack}, 0);
    check("rst_addr",  sram_addr, 0);
    check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);

    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    step();

    // ---- CPU read, WAIT_STATES=2 ----
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010; sram_rdata = 16'h1234;
    capture(8, 1);
    check("rd_cpu_ack_tr", tr_cpu, 16'h0010);
    check("rd_dbg_ack_tr", tr_dbg, 16'h0000);
    check("rd_oe_tr",      tr_oe,  16'h000E);
    check("rd_we_tr",      tr_we,  16'h0000);
    check("rd_drive_tr",   tr_drv, 16'h0000);
    check("rd_busy_tr",    tr_busy, 16'h001E);
    check("rd_addr",       sram_addr, 20'h00010);
    check("rd_cpu_rdata",  cpu_rdata, 16'h1234);

    // ---- DBG read ----
    dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00002; sram_rdata = 16'h5A5A;
    capture(8, 1);
    check("dbgrd_ack_tr",    tr_dbg, 16'h0010);
    check("dbgrd_cpuack_tr", tr_cpu, 16'h0000);
    check("dbgrd_rdata",     dbg_rdata, 16'h5A5A);
    check("dbgrd_cpu_rdata", cpu_rdata, 16'h1234);

    // ---- CPU write ----
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h0FFFF; cpu_wdata = 16'hBEEF;
    sram_rdata = 16'hDEAD;
    capture(8, 1);
    check("wr_ack_tr",   tr_cpu, 16'h0010);
    check("wr_we_tr",    tr_we,  16'h000C);
    check("wr_oe_tr",    tr_oe,  16'h0000);
    check("wr_drive_tr", tr_drv, 16'h001E);
    check("wr_wdata_tr", tr_wd & 16'h001E, 16'h001E);
    check("wr_addr",     sram_addr, 20'h0FFFF);
    check("wr_rdata_kept", {cpu_rdata, dbg_rdata}, {16'h1234, 16'h5A5A});

    // ---- simultaneous requests (last grant was CPU) ----
    cpu_we = 0; cpu_addr = 20'h00020; dbg_addr = 20'h00030; sram_rdata = 16'h7777;
    cpu_req = 1; dbg_req = 1;
    capture(14, 1);
`ifdef MEM_SEQ_RR_ARB_EN
    check("sim_cpu_ack_tr", tr_cpu, 16'h0200);
    check("sim_dbg_ack_tr", tr_dbg, 16'h0010);
`else
    check("sim_cpu_ack_tr", tr_cpu, 16'h0010);
    check("sim_dbg_ack_tr", tr_dbg, 16'h0200);
`endif
    check("sim_one_ack",  tr_cpu & tr_dbg, 16'h0000);
    check("sim_rdata", {cpu_rdata, dbg_rdata}, {16'h7777, 16'h7777});

    // ---- back-to-back CPU reads, req held ----
    dbg_ref = 16'h7777; sram_rdata = 16'h0ABC; cpu_addr = 20'h00040;
    cpu_req = 1;
    capture(16, 3);
    check("b2b_ack_tr",    tr_cpu, 16'h4210);
    check("b2b_dbg_ack",   tr_dbg, 16'h0000);
    check("b2b_dbg_stable", tr_dchg, 16'h0000);
    check("b2b_cpu_rdata", cpu_rdata, 16'h0ABC);

    // ---- address change during ACCESS is ignored ----
    cpu_req = 1; cpu_addr = 20'h00100; sram_rdata = 16'h4321;
    step(); step();                    // now in cycle 2 (ACCESS)
    cpu_addr = 20'h3FFFF;
    step();                            // cycle 3
    check("addr_frozen", sram_addr, 20'h00100);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (cpu_ack) seen = 1;
      else step();
    end
    check("addr_chg_ack_seen", seen, 1);
    check("addr_chg_rdata", cpu_rdata, 16'h4321);
    cpu_req = 0;
    step(); step();

    // ---- WAIT_STATES=1 latency ----
    w1_req = 1; sram_rdata = 16'h00F1;
    w1_ack_tr = '0; w1_oe_tr = '0;
    for (int c = 0; c < 8; c++) begin
      w1_ack_tr[c] = w1_cpu_ack;
      w1_oe_tr[c]  = ~w1_oe_n;
      if (w1_cpu_ack) w1_req = 0;
      step();
    end
    check("ws1_ack_tr", w1_ack_tr, 16'h0008);
    check("ws1_oe_tr",  w1_oe_tr,  16'h0006);
    check("ws1_rdata",  w1_cpu_rdata, 16'h00F1);

    // ---- reset mid-ACCESS of a write ----
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00055; cpu_wdata = 16'hBEEF;
    step(); step();                    // cycle 2 (ACCESS)
    check("mid_we_low", sram_we_n, 0);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_strobes", {sram_we_n, sram_drive, sram_ce_n}, 3'b101);
    check("abort_busy", busy, 0);
    cpu_req = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;
    step();
    capture(8, 1);
    check("abort_no_ack", tr_cpu | tr_dbg, 16'h0000);
    check("abort_idle",   tr_busy, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
